// File: rtl/alu_mult_seq.sv
// Unsigned 16x16 shift-and-add multiplier that drives the shared ALU (ADD/SLL/SRL).
// Define MULSEQ_EARLY_TERM_EN to stop as soon as the remaining multiplier bits are zero.
module alu_mult_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic        busy,
  output logic        done,
  output logic [31:0] product,
  output logic        ovf,
  output logic [5:0]  alu_opcode,
  output logic [31:0] alu_in1,
  output logic [31:0] alu_in2,
  input  logic [31:0] alu_out
);

  localparam logic [5:0] OP_ADD   = 6'h20;
  localparam logic [5:0] OP_SRL   = 6'h26;
  localparam logic [5:0] OP_SLL   = 6'h27;
  localparam logic [5:0] OP_NOP   = 6'h3F;
  localparam logic [4:0] ITER_MAX = 5'd16;

  typedef enum logic [2:0] {
    S_IDLE, S_TEST, S_ADD, S_SHL, S_SHR, S_DONE
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] acc, mcand;
  logic [15:0] mplier;
  logic [4:0]  cnt;
  logic        term;

`ifdef MULSEQ_EARLY_TERM_EN
  assign term = (mplier == 16'd0) || (cnt == ITER_MAX);
`else
  assign term = (cnt == ITER_MAX);
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (start) state_nxt = S_TEST;
      S_TEST: begin
        if (term)           state_nxt = S_DONE;
        else if (mplier[0]) state_nxt = S_ADD;
        else                state_nxt = S_SHL;
      end
      S_ADD:  state_nxt = S_SHL;
      S_SHL:  state_nxt = S_SHR;
      S_SHR:  state_nxt = S_TEST;
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // ALU ownership is limited to the three arithmetic states
  always_comb begin
    busy       = (state != S_IDLE);
    done       = (state == S_DONE);
    alu_opcode = OP_NOP;
    alu_in1    = 32'd0;
    alu_in2    = 32'd0;
    case (state)
      S_ADD: begin
        alu_opcode = OP_ADD;
        alu_in1    = acc;
        alu_in2    = mcand;
      end
      S_SHL: begin
        alu_opcode = OP_SLL;
        alu_in1    = mcand;
        alu_in2    = 32'd1;
      end
      S_SHR: begin
        alu_opcode = OP_SRL;
        alu_in1    = {16'd0, mplier};
        alu_in2    = 32'd1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc     <= 32'd0;
      mcand   <= 32'd0;
      mplier  <= 16'd0;
      cnt     <= 5'd0;
      product <= 32'd0;
      ovf     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          acc    <= 32'd0;
          mcand  <= {16'd0, op_a[15:0]};
          mplier <= op_b[15:0];
          cnt    <= 5'd0;
          ovf    <= (|op_a[31:16]) | (|op_b[31:16]);
        end
        // product is loaded on the way into DONE so it is valid alongside done
        S_TEST: if (term) product <= acc;
        S_ADD:  acc <= alu_out;
        S_SHL:  mcand <= alu_out;
        S_SHR: begin
          mplier <= alu_out[15:0];
          cnt    <= cnt + 5'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/alu_mult_seq.md
# alu_mult_seq

Multi-cycle unsigned 16x16 multiply sequencer that borrows the shared combinational ALU and drives it with ADD, SLL and SRL opcodes to form a 32-bit product by shift-and-add. It sits beside the CPU execute stage and owns the ALU opcode/operand inputs only while `busy` is high. The result and an operand-range overflow flag are held until the next accepted `start`.

## Interface
Parameters: none; the iteration limit is fixed at 16.

Ports:
- `clk` in 1: single clock; all state updates on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: request; sampled only in IDLE.
- `op_a` in 32: multiplicand; bits [15:0] are used.
- `op_b` in 32: multiplier; bits [15:0] are used.
- `busy` out 1: high from the edge after `start` is accepted until DONE is left.
- `done` out 1: one-cycle pulse in the DONE state.
- `product` out 32: result register.
- `ovf` out 1: set if `op_a[31:16]` or `op_b[31:16]` was nonzero at the accepted start.
- `alu_opcode` out 6: ADD 6'h20, SRL 6'h26, SLL 6'h27, NO_OP 6'h3F.
- `alu_in1` out 32: ALU operand 1.
- `alu_in2` out 32: ALU operand 2 / shift amount.
- `alu_out` in 32: ALU result. It is valid combinationally in the same cycle for ADD/SLL/SRL and is high-Z for NO_OP.

## Operation
- Internal registers: `acc`[31:0], `mcand`[31:0], `mplier`[15:0], `cnt`[4:0].
- States: IDLE, TEST, ADD, SHL, SHR, DONE. Each state lasts exactly one cycle.
- **IDLE**
  - `start`=1 loads `acc`=0, `mcand`={16'b0,`op_a[15:0]`}, `mplier`=`op_b[15:0]`, `cnt`=0, and `ovf`; next state is TEST.
  - `start`=0 stays in IDLE.
- **TEST**
  - No ALU use.
  - If the terminate condition holds, go to DONE.
  - Otherwise go to ADD if `mplier[0]`, else to SHL.
- **ADD**: opcode ADD, in1=`acc`, in2=`mcand`. Capture `acc`<=`alu_out`; next state SHL.
- **SHL**: opcode SLL, in1=`mcand`, in2=1. Capture `mcand`<=`alu_out`; next state SHR.
- **SHR**
  - Opcode SRL, in1={16'b0,`mplier`}, in2=1.
  - Capture `mplier`<=`alu_out[15:0]` and increment `cnt`.
  - Next state TEST.
- **DONE**: `product`<=`acc` on entry, so `product` is valid while `done`=1. Next state IDLE.
- In IDLE, TEST and DONE the block drives `alu_opcode`=NO_OP, `alu_in1`=`alu_in2`=0 and never samples `alu_out`.
- ALU flags N/Z/V are not used. Unsigned product of 16-bit operands cannot exceed 32 bits, so no arithmetic overflow is possible.
- `start` while not in IDLE is ignored; there is no queueing.
- `op_a`/`op_b` changes after acceptance have no effect.
- `product` and `ovf` hold their values until the next accepted `start`. `ovf` updates at acceptance; `product` updates only in DONE.

## Timing
- Reset values: state IDLE, `busy`=0, `done`=0, `product`=0, `ovf`=0, `alu_opcode`=NO_OP, `alu_in1`=`alu_in2`=0; internal registers 0.
- `rst` overrides `start` in the same cycle.
- `rst` mid-operation aborts to IDLE, clears `product` and `ovf`, and produces no `done`.
- Define edge 0 as the edge that samples `start`=1 in IDLE. `done` is high after edge L, and `busy` is high after edges 0..L.
- With early termination: L = 1 + 4·(ones in b[15:0] up to its MSB) + 3·(zeros below the MSB).
  - b=0 gives L=1.
  - b=0xFFFF gives L=65.
- Back-to-back: `start` may be accepted in the IDLE cycle immediately following DONE.

## Configuration
- `MULSEQ_EARLY_TERM_EN` defined: the terminate condition is `mplier`==0 || `cnt`==16. Latency depends on the data, per the formula above.
- Undefined: the terminate condition is `cnt`==16 only. L = 49 + (number of ones in b[15:0]), e.g. b=0 gives L=49 and b=0xFFFF gives L=65.
- The product value is identical in both builds.

## Test plan
- a=3, b=5 (early-term build) -> `product`=15, `ovf`=0, `done` after edge 12. ALU opcode sequence: ADD, SLL, SRL, SLL, SRL, ADD, SLL, SRL.
- a=0x1234, b=0 -> `product`=0, L=1 (early-term) or 49 (without), and no ADD is ever issued.
- a=0xFFFF, b=0xFFFF -> `product`=0xFFFE0001, L=65 in both builds.
- a=0x00010002, b=0x00000003 -> `ovf`=1 after edge 0, `product`=6.
- Pulse `start` with a=7, b=9 during busy, then a=2, b=2 after `done` -> first `product`=63, second `product`=4. The mid-operation `start` is ignored.
- `rst` asserted 5 cycles into a=3, b=5 -> `busy`=0, `product`=0, opcode NO_OP on the next edge, and no `done` pulse.
